// File: rtl/edge_req_gen_if.sv
// Cacheline read-request bus from edge_req_gen to the HBM edge reader.
// master drives the request payload, slave returns req_ready.
interface edge_req_gen_if #(
   parameter int V_ID_WIDTH = 20,
   parameter int HBM_AWIDTH = 34
);
   logic [HBM_AWIDTH-1:0] req_addr;
   logic [V_ID_WIDTH-1:0] req_v_id;
   logic [4:0]            req_first_idx;
   logic [4:0]            req_last_idx;
   logic                  req_last;
   logic                  req_valid;
   logic                  req_ready;

   modport master (
      output req_addr, req_v_id, req_first_idx, req_last_idx, req_last, req_valid,
      input  req_ready
   );

   modport slave (
      input  req_addr, req_v_id, req_first_idx, req_last_idx, req_last, req_valid,
      output req_ready
   );
endinterface

// File: rtl/edge_req_gen.sv
// Splits each vertex edge range [loffset, roffset) into 128 B HBM line requests.
// Optional EDGE_REQ_STAT_EN adds vertex/request statistic counters.
module edge_req_gen #(
   parameter int V_ID_WIDTH   = 20,
   parameter int V_OFF_DWIDTH = 32,
   parameter int HBM_AWIDTH   = 34,
   parameter int FIFO_AWIDTH  = 4,
   parameter int AF_THRESH    = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [HBM_AWIDTH-1:0]   edge_base,
   input  logic [V_ID_WIDTH-1:0]   in_v_id,
   input  logic [V_OFF_DWIDTH-1:0] in_loffset,
   input  logic [V_OFF_DWIDTH-1:0] in_roffset,
   input  logic                    in_valid,
   output logic                    in_almost_full,
   edge_req_gen_if.master          req,
   output logic                    err_offset,
   output logic                    err_overflow,
   output logic                    idle
`ifdef EDGE_REQ_STAT_EN
   ,
   output logic [31:0]             stat_vtx_cnt,
   output logic [31:0]             stat_req_cnt
`endif
);

   localparam int EW    = V_ID_WIDTH + 2 * V_OFF_DWIDTH;
   localparam int DEPTH = 1 << FIFO_AWIDTH;
   localparam int LW    = V_OFF_DWIDTH - 5;

   typedef enum logic {S_IDLE, S_ISSUE} state_t;
   state_t state, state_n;

   logic [EW-1:0]          mem [DEPTH];
   logic [FIFO_AWIDTH:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, cnt_n;
   logic                   empty, full, wr_en, pop, load, adv, bad;

   logic [V_ID_WIDTH-1:0]   h_vid;
   logic [V_OFF_DWIDTH-1:0] h_loff, h_roff, h_rm1;
   logic [LW-1:0]           h_first_line, h_last_line;
   logic [HBM_AWIDTH-1:0]   base_line, h_addr;

   logic [LW-1:0]           cur_line, last_line, next_line;
   logic [4:0]              last_sub;
   logic [HBM_AWIDTH-1:0]   addr_q;
   logic [V_ID_WIDTH-1:0]   vid_q;
   logic [4:0]              fidx_q, lidx_q;
   logic                    last_q;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[FIFO_AWIDTH] != rd_ptr[FIFO_AWIDTH]) &&
                     (wr_ptr[FIFO_AWIDTH-1:0] == rd_ptr[FIFO_AWIDTH-1:0]);
   // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
   assign wr_en    = in_valid && (!full || pop);
   assign wr_ptr_n = wr_ptr + (FIFO_AWIDTH+1)'(wr_en);
   assign rd_ptr_n = rd_ptr + (FIFO_AWIDTH+1)'(pop);
   assign cnt_n    = wr_ptr_n - rd_ptr_n;

   assign {h_vid, h_loff, h_roff} = mem[rd_ptr[FIFO_AWIDTH-1:0]];
   assign h_rm1        = h_roff - V_OFF_DWIDTH'(1);
   assign h_first_line = h_loff[V_OFF_DWIDTH-1:5];
   assign h_last_line  = h_rm1[V_OFF_DWIDTH-1:5];
   assign base_line    = edge_base & ~HBM_AWIDTH'(7'h7F);
   assign h_addr       = base_line + (HBM_AWIDTH'(h_first_line) << 7);
   assign next_line    = cur_line + LW'(1);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[FIFO_AWIDTH-1:0]] <= {in_v_id, in_loffset, in_roffset};
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      pop     = 1'b0;
      load    = 1'b0;
      adv     = 1'b0;
      bad     = 1'b0;
      case (state)
         S_IDLE:  pop = !empty;
         S_ISSUE: begin
            if (req.req_ready) begin
               if (last_q) begin
                  pop     = !empty;
                  state_n = S_IDLE;
               end else begin
                  adv = 1'b1;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
      if (pop) begin
         if (h_loff < h_roff) begin
            load    = 1'b1;
            state_n = S_ISSUE;
         end else begin
            state_n = S_IDLE;
            bad     = (h_loff > h_roff);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         in_almost_full <= 1'b0;
         err_offset     <= 1'b0;
         err_overflow   <= 1'b0;
      end else begin
         wr_ptr         <= wr_ptr_n;
         rd_ptr         <= rd_ptr_n;
         in_almost_full <= (cnt_n >= (FIFO_AWIDTH+1)'(AF_THRESH));
         if (bad)                err_offset   <= 1'b1;
         if (in_valid && !wr_en) err_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q    <= '0;
         vid_q     <= '0;
         fidx_q    <= '0;
         lidx_q    <= '0;
         last_q    <= 1'b0;
         last_sub  <= '0;
         cur_line  <= '0;
         last_line <= '0;
      end else if (load) begin
         addr_q    <= h_addr;
         vid_q     <= h_vid;
         fidx_q    <= h_loff[4:0];
         last_sub  <= h_rm1[4:0];
         cur_line  <= h_first_line;
         last_line <= h_last_line;
         last_q    <= (h_first_line == h_last_line);
         lidx_q    <= (h_first_line == h_last_line) ? h_rm1[4:0] : '1;
      end else if (adv) begin
         addr_q   <= addr_q + HBM_AWIDTH'(128);
         fidx_q   <= '0;
         cur_line <= next_line;
         last_q   <= (next_line == last_line);
         lidx_q   <= (next_line == last_line) ? last_sub : '1;
      end
   end

   assign req.req_valid     = (state == S_ISSUE);
   assign req.req_addr      = addr_q;
   assign req.req_v_id      = vid_q;
   assign req.req_first_idx = fidx_q;
   assign req.req_last_idx  = lidx_q;
   assign req.req_last      = last_q;

   assign idle = empty && (state == S_IDLE) && !req.req_valid;

`ifdef EDGE_REQ_STAT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_vtx_cnt <= '0;
         stat_req_cnt <= '0;
      end else if (req.req_valid && req.req_ready) begin
         stat_req_cnt <= stat_req_cnt + 32'd1;
         if (last_q) stat_vtx_cnt <= stat_vtx_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_edge_req_gen.sv
// Directed self-checking bench for edge_req_gen (stats ports checked when
// EDGE_REQ_STAT_EN is defined).
module tb_edge_req_gen;
   logic        clk = 1'b0;
   logic        rst;
   logic [33:0] edge_base;
   logic [19:0] in_v_id;
   logic [31:0] in_loffset, in_roffset;
   logic        in_valid;
   logic        in_almost_full, err_offset, err_overflow, idle;
`ifdef EDGE_REQ_STAT_EN
   logic [31:0] stat_vtx_cnt, stat_req_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   edge_req_gen_if #(.V_ID_WIDTH(20), .HBM_AWIDTH(34)) bus ();

   edge_req_gen #(
      .V_ID_WIDTH(20), .V_OFF_DWIDTH(32), .HBM_AWIDTH(34),
      .FIFO_AWIDTH(4), .AF_THRESH(8)
   ) dut (
      .clk(clk), .rst(rst), .edge_base(edge_base),
      .in_v_id(in_v_id), .in_loffset(in_loffset), .in_roffset(in_roffset),
      .in_valid(in_valid), .in_almost_full(in_almost_full), .req(bus),
      .err_offset(err_offset), .err_overflow(err_overflow), .idle(idle)
`ifdef EDGE_REQ_STAT_EN
      , .stat_vtx_cnt(stat_vtx_cnt), .stat_req_cnt(stat_req_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [19:0] v, input logic [31:0] lo, input logic [31:0] ro);
      in_valid   = 1'b1;
      in_v_id    = v;
      in_loffset = lo;
      in_roffset = ro;
   endtask

   task automatic expect_req(input string tag, input logic [33:0] a, input logic [19:0] v,
                             input logic [4:0] f, input logic [4:0] l, input logic lst);
      chk({tag, "/valid"}, 64'(bus.req_valid), 64'd1);
      chk({tag, "/addr"},  64'(bus.req_addr), 64'(a));
      chk({tag, "/vid"},   64'(bus.req_v_id), 64'(v));
      chk({tag, "/first"}, 64'(bus.req_first_idx), 64'(f));
      chk({tag, "/lastix"},64'(bus.req_last_idx), 64'(l));
      chk({tag, "/last"},  64'(bus.req_last), 64'(lst));
   endtask

   task automatic expect_none(input string tag);
      chk({tag, "/valid"}, 64'(bus.req_valid), 64'd0);
   endtask

   initial begin
      int unsigned exp_v;
      int unsigned n;
      rst = 1'b1; in_valid = 1'b0; in_v_id = '0; in_loffset = '0; in_roffset = '0;
      edge_base = 34'h1000; bus.req_ready = 1'b1;
      repeat (3) tick();

      // reset state
      expect_none("rst");
      chk("rst/addr", 64'(bus.req_addr), 64'd0);
      chk("rst/vid", 64'(bus.req_v_id), 64'd0);
      chk("rst/af", 64'(in_almost_full), 64'd0);
      chk("rst/erro", 64'(err_offset), 64'd0);
      chk("rst/errv", 64'(err_overflow), 64'd0);
      chk("rst/idle", 64'(idle), 64'd1);
      rst = 1'b0;
      tick();

      // 1: single full line, N+2 latency
      push(5, 0, 32); tick(); in_valid = 1'b0;
      expect_none("t1/n1");
      chk("t1/busy", 64'(idle), 64'd0);
      tick(); expect_req("t1", 34'h1000, 5, 0, 31, 1);
      tick(); expect_none("t1/end");
      chk("t1/idle", 64'(idle), 64'd1);

      // 2: three lines
      push(7, 30, 70); tick(); in_valid = 1'b0;
      tick(); expect_req("t2a", 34'h1000, 7, 30, 31, 0);
      tick(); expect_req("t2b", 34'h1080, 7, 0, 31, 0);
      tick(); expect_req("t2c", 34'h1100, 7, 0, 5, 1);
      tick(); expect_none("t2/end");

      // 3: empty range dropped, inverted range flagged, then normal vertex
      push(1, 100, 100); tick(); expect_none("t3/n1");
      push(2, 200, 100); tick(); expect_none("t3/n2");
      chk("t3/err0", 64'(err_offset), 64'd0);
      push(9, 64, 65); tick(); in_valid = 1'b0;
      expect_none("t3/n3");
      chk("t3/err1", 64'(err_offset), 64'd1);
      tick(); expect_req("t3", 34'h1100, 9, 0, 0, 1);
      tick(); expect_none("t3/end");

      // 4: stall, almost-full, overflow
      bus.req_ready = 1'b0;
      for (int i = 0; i < 18; i++) begin
         push(20'(10 + i), 32'(i * 32), 32'(i * 32 + 32));
         tick();
         if (i >= 1) begin
            chk("t4/hold_v", 64'(bus.req_v_id), 64'd10);
            chk("t4/hold_a", 64'(bus.req_addr), 64'h1000);
         end
         if (i == 7)  chk("t4/af_lo", 64'(in_almost_full), 64'd0);
         if (i == 8)  chk("t4/af_hi", 64'(in_almost_full), 64'd1);
         if (i == 16) chk("t4/ovf0", 64'(err_overflow), 64'd0);
         if (i == 17) chk("t4/ovf1", 64'(err_overflow), 64'd1);
      end
      in_valid = 1'b0;
      repeat (2) tick();
      expect_req("t4/stall", 34'h1000, 10, 0, 31, 1);
      bus.req_ready = 1'b1;
      exp_v = 10; n = 0;
      while (!idle && n < 60) begin
         if (bus.req_valid) begin
            chk("t4/drain_v", 64'(bus.req_v_id), 64'(exp_v));
            chk("t4/drain_a", 64'(bus.req_addr), 64'(34'h1000 + 34'((exp_v - 10) * 128)));
            exp_v++;
         end
         tick(); n++;
      end
      chk("t4/idle", 64'(idle), 64'd1);
      chk("t4/count", 64'(exp_v), 64'd27);
      chk("t4/af_end", 64'(in_almost_full), 64'd0);
      chk("t4/sticky", 64'(err_overflow), 64'd1);

      // 5: reset mid-issue
      push(3, 0, 96); tick(); in_valid = 1'b0;
      tick(); expect_req("t5a", 34'h1000, 3, 0, 31, 0);
      tick(); expect_req("t5b", 34'h1080, 3, 0, 31, 0);
      rst = 1'b1; tick(); rst = 1'b0;
      expect_none("t5/rst");
      chk("t5/idle", 64'(idle), 64'd1);
      chk("t5/erro", 64'(err_offset), 64'd0);
      chk("t5/errv", 64'(err_overflow), 64'd0);
      chk("t5/addr", 64'(bus.req_addr), 64'd0);
      tick(); expect_none("t5/quiet");
      push(4, 33, 40); tick(); in_valid = 1'b0;
      tick(); expect_req("t5c", 34'h1080, 4, 1, 7, 1);
      tick(); expect_none("t5/end");

      // 6: back-to-back single-line vertices
      rst = 1'b1; tick(); rst = 1'b0;
      push(20, 0, 1); tick();
      push(21, 32, 64); tick(); in_valid = 1'b0;
      expect_req("t6a", 34'h1000, 20, 0, 0, 1);
      tick(); expect_req("t6b", 34'h1080, 21, 0, 31, 1);
      tick(); expect_none("t6/end");
      chk("t6/idle", 64'(idle), 64'd1);
`ifdef EDGE_REQ_STAT_EN
      chk("t6/vtx", 64'(stat_vtx_cnt), 64'd2);
      chk("t6/req", 64'(stat_req_cnt), 64'd2);
`endif

      // base low bits ignored and address wraps at 2^34
      edge_base = 34'h3_FFFF_FFC5;
      push(30, 32, 33); tick(); in_valid = 1'b0;
      tick(); expect_req("wrap", 34'h0, 30, 0, 0, 1);
      tick(); expect_none("wrap/end");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
